ulpb_sleep_req_gen: RTL

- Upstream neighbour of the layer sleep controller; produces the SLEEP_REQ level that the controller samples to start its isolate/reset/power-off sequence.
- Turns a one-cycle sleep command from bus control into a safe request. It waits for bus and local transfers to drain, then applies a guard delay. A wake-up event or a drain timeout aborts the request.

---
 rtl/ulpb_sleep_req_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ulpb_sleep_req_gen.sv
// rtl/ulpb_sleep_req_gen.sv - sleep request generator ahead of the layer sleep controller
//
// Purpose:
//   Turns a one-cycle sleep command from bus control into a safe SLEEP_REQ
//   level. The command first waits for bus and local transfers to drain
//   (bounded by a timeout), then waits a guard interval of continuous idle
//   cycles before raising the request. A wake-up event or a drain timeout
//   cancels the pending sleep and reports why.
//
// Parameters:
//   GUARD_CYCLES   - idle cycles required after drain before SLEEP_REQ rises
//   TIMEOUT_CYCLES - maximum cycles spent waiting for drain before abort
//   CNT_WIDTH      - width of the shared down-counter
//
// Ports:
//   CLKIN          in   block clock, rising edge
//   RESET          in   synchronous active-high reset
//   SLEEP_CMD      in   one-cycle sleep command pulse
//   WAKEUP_REQ     in   wake-up / interrupt pending, cancels sleep
//   BUS_BUSY       in   bus transaction in progress
//   TX_PEND        in   local transmit not yet complete
//   RX_PEND        in   local receive buffer not yet consumed
//   SLEEP_REQ      out  level to the sleep controller, high = enter sleep
//   SLEEP_PENDING  out  high while a sleep command is in progress
//   SLEEP_ABORT    out  one-cycle pulse when a pending sleep is cancelled
//   ABORT_CAUSE    out  valid with SLEEP_ABORT: 0 = wake-up, 1 = drain timeout

module ulpb_sleep_req_gen #(
  parameter int GUARD_CYCLES   = 16,
  parameter int TIMEOUT_CYCLES = 200,
  parameter int CNT_WIDTH      = 8
) (
  input  logic CLKIN,
  input  logic RESET,
  input  logic SLEEP_CMD,
  input  logic WAKEUP_REQ,
  input  logic BUS_BUSY,
  input  logic TX_PEND,
  input  logic RX_PEND,
  output logic SLEEP_REQ,
  output logic SLEEP_PENDING,
  output logic SLEEP_ABORT,
  output logic ABORT_CAUSE
);

  // The counter is loaded with N-1 so that the terminal decision is taken on
  // the edge where it already reads zero, giving exactly N cycles per phase.
  localparam logic [CNT_WIDTH-1:0] GUARD_LOAD   = CNT_WIDTH'(GUARD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GUARD = 2'd2,
    ST_REQ   = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   cnt_nxt;
  logic [CNT_WIDTH-1:0]   cnt_dec;
  logic                   cnt_zero;
  logic                   abort_nxt;
  logic                   cause_nxt;
  logic                   busy;

  assign busy     = BUS_BUSY | TX_PEND | RX_PEND;
  assign cnt_zero = (cnt == CNT_ZERO);
  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec  = cnt_zero ? CNT_ZERO : (cnt - CNT_ONE);

  // Next-state and next-output logic. WAKEUP_REQ is tested first in every
  // active state so a wake-up always wins over drain/guard/timeout decisions.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort_nxt = 1'b0;
    cause_nxt = ABORT_CAUSE;

    case (state)
      ST_IDLE: begin
        // A command arriving together with a wake-up is dropped silently.
        if (SLEEP_CMD && !WAKEUP_REQ) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = TIMEOUT_LOAD;
        end
      end

      ST_DRAIN: begin
        if (WAKEUP_REQ) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
          abort_nxt = 1'b1;
          cause_nxt = 1'b0;
        end else if (!busy) begin
          // Drain completing on the timeout cycle still lets sleep proceed.
          state_nxt = ST_GUARD;
          cnt_nxt   = GUARD_LOAD;
        end else if (cnt_zero) begin
          state_nxt = ST_IDLE;
          abort_nxt = 1'b1;
          cause_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      ST_GUARD: begin
        if (WAKEUP_REQ) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = CNT_ZERO;
          abort_nxt = 1'b1;
          cause_nxt = 1'b0;
        end else if (busy) begin
          // New activity during the guard restarts the whole drain wait.
          state_nxt = ST_DRAIN;
          cnt_nxt   = TIMEOUT_LOAD;
        end else if (cnt_zero) begin
          state_nxt = ST_REQ;
        end else begin
          cnt_nxt = cnt_dec;
        end
      end

      ST_REQ: begin
        // The request is committed: activity is ignored, only a wake-up
        // withdraws it. Otherwise the domain reset clears it after power-off.
        if (WAKEUP_REQ) begin
          state_nxt = ST_IDLE;
          abort_nxt = 1'b1;
          cause_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State register. Outputs are registered from the next state so that they
  // change on the same edge as the state they describe.
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state         <= ST_IDLE;
      cnt           <= CNT_ZERO;
      SLEEP_REQ     <= 1'b0;
      SLEEP_PENDING <= 1'b0;
      SLEEP_ABORT   <= 1'b0;
      ABORT_CAUSE   <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      SLEEP_REQ     <= (state_nxt == ST_REQ);
      SLEEP_PENDING <= (state_nxt != ST_IDLE);
      SLEEP_ABORT   <= abort_nxt;
      ABORT_CAUSE   <= cause_nxt;
    end
  end

endmodule
